// File: rtl/rec_df_ram1_arbiter.sv
// Single-port RAM arbiter between the reconstruction writer (rec) and the deblocking reader (DF).
// Grants and RAM strobes are combinational; hold copies, starvation counter and read-valid pipe are registered.
module rec_df_ram1_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned RAM_DEPTH  = 96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rec_req,
  input  logic [6:0]  rec_addr,
  input  logic [31:0] rec_din,
  output logic        rec_gnt,
  input  logic        DF_req,
  input  logic [6:0]  DF_addr,
  output logic        DF_gnt,
  output logic        DF_dout_valid,
  output logic        rec_DF_RAM1_cs_n,
  output logic        rec_DF_RAM1_wr,
  output logic [6:0]  rec_DF_RAM1_addr,
  output logic [31:0] rec_DF_RAM1_din,
  input  logic        err_clr,
  output logic        addr_err
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 3;

  logic [CW-1:0] starve_cnt;
  logic [AW-1:0] addr_hold;
  logic [DW-1:0] din_hold;
  logic [1:0]    valid_pipe;

  logic rec_win;
  logic rec_in_range;
  logic df_in_range;
  logic rec_access;
  logic df_access;
  logic bad_grant;

  // Arbitration and RAM strobe generation; reset forces every strobe idle.
  always_comb begin
    rec_win          = 1'b0;
    rec_gnt          = 1'b0;
    DF_gnt           = 1'b0;
    rec_in_range     = (32'(rec_addr) < RAM_DEPTH);
    df_in_range      = (32'(DF_addr) < RAM_DEPTH);
    rec_access       = 1'b0;
    df_access        = 1'b0;
    bad_grant        = 1'b0;
    rec_DF_RAM1_cs_n = 1'b1;
    rec_DF_RAM1_wr   = 1'b0;
    rec_DF_RAM1_addr = addr_hold;
    rec_DF_RAM1_din  = din_hold;
    if (!reset) begin
      rec_win    = rec_req && (!DF_req || (starve_cnt == CW'(STARVE_MAX)));
      rec_gnt    = rec_win;
      DF_gnt     = DF_req && !rec_win;
      rec_access = rec_gnt && rec_in_range;
      df_access  = DF_gnt && df_in_range;
      bad_grant  = (rec_gnt && !rec_in_range) || (DF_gnt && !df_in_range);
      if (rec_access) begin
        rec_DF_RAM1_cs_n = 1'b0;
        rec_DF_RAM1_wr   = 1'b1;
        rec_DF_RAM1_addr = rec_addr;
        rec_DF_RAM1_din  = rec_din;
      end else if (df_access) begin
        rec_DF_RAM1_cs_n = 1'b0;
        rec_DF_RAM1_addr = DF_addr;
      end
    end
  end

  // Starvation counter: counts consecutive cycles rec waits while requesting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (!rec_req || rec_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CW'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Hold copies so the RAM bus keeps its last driven address/data when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_hold <= '0;
      din_hold  <= '0;
    end else begin
      if (rec_access || df_access) addr_hold <= rec_DF_RAM1_addr;
      if (rec_access)              din_hold  <= rec_din;
    end
  end

  // Read-valid pipe matches the RAM's two-cycle read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_pipe <= '0;
    end else begin
      valid_pipe <= {valid_pipe[0], DF_gnt};
    end
  end

  assign DF_dout_valid = valid_pipe[1];

  // Sticky address error; a new error beats a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_err <= 1'b0;
    end else if (bad_grant) begin
      addr_err <= 1'b1;
    end else if (err_clr) begin
      addr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rec_df_ram1_arbiter.sv
// Randomized bench for rec_df_ram1_arbiter against a cycle-level behavioural model,
// with a two-cycle-latency RAM attached to the arbiter's RAM port.
module tb_rec_df_ram1_arbiter;

  localparam int STARVE = 4;
  localparam int DEPTH  = 96;

  logic        clk = 1'b0;
  logic        reset;
  logic        rec_req;
  logic [6:0]  rec_addr;
  logic [31:0] rec_din;
  logic        rec_gnt;
  logic        DF_req;
  logic [6:0]  DF_addr;
  logic        DF_gnt;
  logic        DF_dout_valid;
  logic        ram_cs_n;
  logic        ram_wr;
  logic [6:0]  ram_addr;
  logic [31:0] ram_din;
  logic        err_clr;
  logic        addr_err;

  rec_df_ram1_arbiter #(.STARVE_MAX(STARVE), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .rec_req(rec_req), .rec_addr(rec_addr), .rec_din(rec_din), .rec_gnt(rec_gnt),
    .DF_req(DF_req), .DF_addr(DF_addr), .DF_gnt(DF_gnt), .DF_dout_valid(DF_dout_valid),
    .rec_DF_RAM1_cs_n(ram_cs_n), .rec_DF_RAM1_wr(ram_wr),
    .rec_DF_RAM1_addr(ram_addr), .rec_DF_RAM1_din(ram_din),
    .err_clr(err_clr), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Attached RAM: synchronous write, read data appears two cycles after the access.
  logic [31:0] ram_mem [128];
  logic [31:0] ram_rd1;
  logic [31:0] ram_dout;
  always @(posedge clk) begin
    if (!ram_cs_n && ram_wr) ram_mem[ram_addr] <= ram_din;
    ram_rd1  <= (!ram_cs_n && !ram_wr) ? ram_mem[ram_addr] : 32'hxxxx_xxxx;
    ram_dout <= ram_rd1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          losses = 0;
  logic [6:0]  m_addr = '0;
  logic [31:0] m_din  = '0;
  logic        m_err  = 1'b0;
  logic [31:0] m_mem [128];
  bit          m_wrt [128];
  bit   [1:0]  p_v  = '0;
  bit   [1:0]  p_ok = '0;
  logic [31:0] p_data [2];

  task automatic cycle(input logic r, input logic rr, input logic [6:0] ra, input logic [31:0] rd,
                       input logic dr, input logic [6:0] da, input logic ec);
    logic e_rg, e_dg, e_cs, e_wr, rec_ok, df_ok;
    logic [6:0]  e_addr;
    logic [31:0] e_din;
    @(negedge clk);
    reset = r; rec_req = rr; rec_addr = ra; rec_din = rd;
    DF_req = dr; DF_addr = da; err_clr = ec;
    #1;
    rec_ok = int'(ra) < DEPTH;
    df_ok  = int'(da) < DEPTH;
    e_rg = 1'b0; e_dg = 1'b0; e_cs = 1'b1; e_wr = 1'b0; e_addr = '0; e_din = '0;
    if (!r) begin
      e_rg   = rr && (!dr || losses >= STARVE);
      e_dg   = dr && !e_rg;
      e_addr = m_addr;
      e_din  = m_din;
      if (e_rg && rec_ok) begin
        e_cs = 1'b0; e_wr = 1'b1; e_addr = ra; e_din = rd;
      end else if (e_dg && df_ok) begin
        e_cs = 1'b0; e_addr = da;
      end
    end
    check("rec_gnt",   32'(rec_gnt),       32'(e_rg));
    check("DF_gnt",    32'(DF_gnt),        32'(e_dg));
    check("cs_n",      32'(ram_cs_n),      32'(e_cs));
    check("wr",        32'(ram_wr),        32'(e_wr));
    check("ram_addr",  32'(ram_addr),      32'(e_addr));
    check("ram_din",   ram_din,            e_din);
    check("dout_valid", 32'(DF_dout_valid), r ? 32'd0 : 32'(p_v[1]));
    check("addr_err",  32'(addr_err),      r ? 32'd0 : 32'(m_err));
    if (!r && p_v[1] && p_ok[1]) check("rd_data", ram_dout, p_data[1]);
    @(posedge clk);
    if (r) begin
      losses = 0; m_addr = '0; m_din = '0; m_err = 1'b0; p_v = '0; p_ok = '0;
    end else begin
      p_v[1] = p_v[0]; p_ok[1] = p_ok[0]; p_data[1] = p_data[0];
      p_v[0] = e_dg; p_ok[0] = df_ok && m_wrt[da]; p_data[0] = m_mem[da];
      if (e_rg && rec_ok) begin
        m_mem[ra] = rd; m_wrt[ra] = 1'b1;
      end
      if (!e_cs) begin
        m_addr = e_addr; m_din = e_din;
      end
      if (!rr || e_rg) losses = 0;
      else if (losses < STARVE) losses = losses + 1;
      if ((e_rg && !rec_ok) || (e_dg && !df_ok)) m_err = 1'b1;
      else if (ec) m_err = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) m_wrt[i] = 1'b0;
    reset = 1'b1; rec_req = 1'b0; rec_addr = '0; rec_din = '0;
    DF_req = 1'b0; DF_addr = '0; err_clr = 1'b0;

    // Reset state
    cycle(1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 1'b0);
    cycle(1'b1, 1'b1, 7'd3, 32'h1234, 1'b1, 7'd4, 1'b0);

    // Write then read back 0xDEADBEEF at address 5
    cycle(1'b0, 1'b1, 7'd5, 32'hDEAD_BEEF, 1'b0, 7'd0, 1'b0);
    cycle(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd5, 1'b0);
    idle(3);

    // Continuous contention: 4 DF grants then one rec grant, repeating
    for (int i = 0; i < 15; i++)
      cycle(1'b0, 1'b1, 7'(10 + i), 32'(i * 7 + 1), 1'b1, 7'(20 + (i % 4)), 1'b0);
    idle(3);

    // Back-to-back reads of addresses 0,1,2
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 7'(i), 32'hA000_0000 + 32'(i), 1'b0, 7'd0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'(i), 1'b0);
    idle(3);

    // Out-of-range write, sticky error, clear, and set-beats-clear
    cycle(1'b0, 1'b1, 7'd96, 32'hBAD0_0001, 1'b0, 7'd0, 1'b0);
    idle(2);
    cycle(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 1'b1);
    idle(1);
    cycle(1'b0, 1'b1, 7'd100, 32'hBAD0_0002, 1'b0, 7'd0, 1'b1);
    idle(1);
    cycle(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd127, 1'b0);
    idle(3);
    cycle(1'b0, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 1'b1);

    // Reset right after a DF grant cancels the pending valid pulse
    cycle(1'b0, 1'b0, 7'd0, 32'd0, 1'b1, 7'd5, 1'b0);
    cycle(1'b1, 1'b0, 7'd0, 32'd0, 1'b0, 7'd0, 1'b0);
    cycle(1'b0, 1'b1, 7'd7, 32'h0707_0707, 1'b0, 7'd0, 1'b0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 299) == 0),
            1'($urandom_range(0, 2) != 0), 7'($urandom_range(0, 103)), 32'($urandom),
            1'($urandom_range(0, 2) != 0), 7'($urandom_range(0, 103)),
            1'($urandom_range(0, 7) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rec_df_ram1_arbiter.md
REC_DF_RAM1_ARBITER -- requirements
Module: rec_DF_RAM1_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4 (range 1..7): consecutive lost contentions after which rec wins.
REQ-002 SHALL have parameter RAM_DEPTH, default 96: number of valid word addresses (0..RAM_DEPTH-1).
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-high, port reset.
REQ-004 Ports (name  direction  width  meaning):
  clk  in  1  system clock
  reset  in  1  async active-high reset
  rec_req  in  1  reconstruction write request, held until granted
  rec_addr  in  7  write word address
  rec_din  in  32  write data
  rec_gnt  out  1  write accepted this cycle
  DF_req  in  1  deblocking read request, held until granted
  DF_addr  in  7  read word address
  DF_gnt  out  1  read accepted this cycle
  DF_dout_valid  out  1  rec_DF_RAM1_dout holds data of the read granted 2 cycles earlier
  rec_DF_RAM1_cs_n  out  1  RAM chip select, active low
  rec_DF_RAM1_wr  out  1  RAM write strobe, 1 = write
  rec_DF_RAM1_addr  out  7  RAM address
  rec_DF_RAM1_din  out  32  RAM write data
  err_clr  in  1  clears addr_err
  addr_err  out  1  sticky: a granted request had address >= RAM_DEPTH

Function
REQ-005 At most one of rec_gnt, DF_gnt SHALL be high per cycle; grants are combinational from requests and registered state.
REQ-006 Only one requester active: that requester SHALL be granted in the same cycle.
REQ-007 Contention (both requests high): DF SHALL win unless starve_cnt == STARVE_MAX, in which case rec SHALL win.
REQ-008 starve_cnt (3 bits) SHALL increment, saturating at STARVE_MAX, on each cycle rec_req is high and rec_gnt low; it SHALL clear to 0 on any cycle rec_gnt is high or rec_req is low.
REQ-009 On rec_gnt with in-range address: cs_n=0, wr=1, addr=rec_addr, din=rec_din in the same cycle.
REQ-010 On DF_gnt with in-range address: cs_n=0, wr=0, addr=DF_addr; din SHALL hold its previous registered value.
REQ-011 No grant: cs_n=1, wr=0; addr and din SHALL hold their last driven values (registered hold copies).
REQ-012 Granted request with address >= RAM_DEPTH: handshake SHALL complete (gnt high), cs_n SHALL stay 1, addr_err SHALL set on the next clock edge.
REQ-013 DF_dout_valid SHALL be a 2-stage shift of DF_gnt: high in cycle N+2 for a DF grant in cycle N, including back-to-back grants (one pulse per grant); for out-of-range reads it still pulses and data is undefined.
REQ-014 addr_err set and err_clr in the same cycle: set SHALL win.
REQ-015 A rec write and a DF read to the same address SHALL never share a cycle (REQ-005); ordering is grant order, so a read granted after a write returns the new data.
REQ-016 Requests dropping before grant SHALL be tolerated with no RAM access and no state change beyond REQ-008.

Reset
REQ-017 While reset is high: rec_gnt=0, DF_gnt=0, DF_dout_valid=0, cs_n=1, wr=0, addr=0, din=0, addr_err=0, starve_cnt=0, valid pipeline cleared.
REQ-018 Reset asserted mid-read SHALL cancel the pending DF_dout_valid pulse; first grant possible in the first cycle after reset deasserts.

Verification
REQ-019 rec_req alone, addr=5, din=0xDEADBEEF -> rec_gnt=1, cs_n=0, wr=1, addr=5 same cycle; then DF_req addr=5 -> DF_dout_valid 2 cycles after DF_gnt, dout=0xDEADBEEF.
REQ-020 Both requests held continuously, STARVE_MAX=4 -> DF granted 4 cycles, rec granted cycle 5, pattern repeats 4:1.
REQ-021 DF_req on 3 consecutive cycles, addrs 0,1,2 -> DF_dout_valid high 3 consecutive cycles starting 2 cycles after first grant, data in address order.
REQ-022 rec_req addr=96 -> rec_gnt=1, cs_n=1, addr_err=1 next cycle; err_clr pulse -> addr_err=0; simultaneous new error and err_clr -> addr_err stays 1.
REQ-023 DF grant then reset asserted next cycle -> DF_dout_valid never pulses, all outputs at REQ-017 values asynchronously.
